// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: collects pass/fail results from a RISC-V self-test program.
// Software writes TEST_ID, EXPECT and ACTUAL, then CTRL END or CLEAR.
// Software reads STATUS, the pass/fail counters and the first failing id.
// Optional per-test watchdog: define RISCV_TEST_MONITOR_WATCHDOG_EN to build it in.
// When the watchdog is not built in, TIMEOUT is never entered and timeout is tied low.
module riscv_test_monitor #(
    parameter int ID_W           = 11,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        any_fail,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

    state_t           state;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  first_fail_id;
    logic [31:0]      expect_val;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail_seen;
    logic             seq_err;
    logic             any_fail_q;
    logic             done_q;

    logic             wr_id;
    logic             wr_exp;
    logic             wr_act;
    logic             end_req;
    logic             clear_req;
    logic [ID_W-1:0]  next_id;

    assign wr_id     = wr_en && (addr == 2'd0);
    assign wr_exp    = wr_en && (addr == 2'd1);
    assign wr_act    = wr_en && (addr == 2'd2);
    assign end_req   = wr_en && (addr == 2'd3) && wdata[0];
    assign clear_req = wr_en && (addr == 2'd3) && wdata[1];
    assign next_id   = cur_id + ID_W'(1);

`ifdef RISCV_TEST_MONITOR_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd;
    logic                 timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign done     = done_q;
    assign any_fail = any_fail_q;

    // Control FSM with result bookkeeping; CLEAR takes priority over every other write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_id        <= '0;
            first_fail_id <= '0;
            expect_val    <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            fail_seen     <= 1'b0;
            seq_err       <= 1'b0;
            any_fail_q    <= 1'b0;
            done_q        <= 1'b0;
`ifdef RISCV_TEST_MONITOR_WATCHDOG_EN
            wd            <= '0;
            timeout_q     <= 1'b0;
`endif
        end else if (clear_req) begin
            state         <= IDLE;
            cur_id        <= '0;
            first_fail_id <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            fail_seen     <= 1'b0;
            seq_err       <= 1'b0;
            any_fail_q    <= 1'b0;
            done_q        <= 1'b0;
`ifdef RISCV_TEST_MONITOR_WATCHDOG_EN
            wd            <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wr_exp) expect_val <= wdata;
                    if (wr_id) begin
                        cur_id <= wdata[ID_W-1:0];
                        state  <= RUN;
`ifdef RISCV_TEST_MONITOR_WATCHDOG_EN
                        wd     <= '0;
`endif
                    end else if (end_req) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_exp) expect_val <= wdata;
                    if (wr_id) begin
                        cur_id <= wdata[ID_W-1:0];
                        if (wdata[ID_W-1:0] != next_id) begin
                            seq_err    <= 1'b1;
                            any_fail_q <= 1'b1;
                        end
                    end
                    if (wr_act) begin
                        if (wdata == expect_val) begin
                            if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
                            any_fail_q <= 1'b1;
                            if (!fail_seen) begin
                                fail_seen     <= 1'b1;
                                first_fail_id <= cur_id;
                            end
                        end
                    end
                    if (end_req) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
`ifdef RISCV_TEST_MONITOR_WATCHDOG_EN
                    else if (wr_id) begin
                        wd <= '0;
                    end else if (wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= TIMEOUT;
                        timeout_q  <= 1'b1;
                        any_fail_q <= 1'b1;
                    end else begin
                        wd <= wd + TIMEOUT_W'(1);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Registered read port; it samples state before any same-cycle write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            case (addr)
                2'd0:    rdata <= {27'd0, seq_err, any_fail_q, timeout, done_q, state == RUN};
                2'd1:    rdata <= 32'(pass_cnt);
                2'd2:    rdata <= 32'(fail_cnt);
                default: rdata <= 32'(first_fail_id);
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed vector table plus hand-written multi-cycle sequences.
// A second instance with 2-bit counters exercises counter saturation.
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        any_fail;
    logic        timeout;
    logic [31:0] rdata_sat;
    logic        done_sat;
    logic        any_fail_sat;
    logic        timeout_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    riscv_test_monitor #(.ID_W(11), .CNT_W(16), .TIMEOUT_W(20), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .any_fail(any_fail), .timeout(timeout)
    );

    riscv_test_monitor #(.ID_W(11), .CNT_W(2), .TIMEOUT_W(20), .TIMEOUT_CYCLES(16)) sat (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata_sat), .done(done_sat), .any_fail(any_fail_sat),
        .timeout(timeout_sat)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input int kind, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string n);
        vec_t v;
        v.kind = kind; v.addr = a; v.data = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        case (v.kind)
            0: do_write(v.addr, v.data);
            1: begin
                do_read(v.addr);
                check_output(v.name, rdata, v.exp);
            end
            default: check_output(v.name, {29'd0, timeout, any_fail, done}, v.exp);
        endcase
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;

        // kind 0 = write, 1 = read and compare rdata, 2 = compare {timeout, any_fail, done}
        add(1, 2'd0, 0, 32'h0, "reset_status");
        add(1, 2'd1, 0, 32'h0, "reset_pass");
        add(1, 2'd2, 0, 32'h0, "reset_fail");
        add(1, 2'd3, 0, 32'h0, "reset_ffid");
        add(0, 2'd0, 32'd1, 0, "");
        add(0, 2'd1, 32'h11223344, 0, "");
        add(0, 2'd2, 32'h11223344, 0, "");
        add(1, 2'd0, 0, 32'h1, "t1_running");
        add(0, 2'd3, 32'd1, 0, "");
        add(1, 2'd1, 0, 32'h1, "t1_pass");
        add(1, 2'd2, 0, 32'h0, "t1_fail");
        add(1, 2'd0, 0, 32'h2, "t1_status_done");
        add(2, 2'd0, 0, 32'h1, "t1_ports");
        add(0, 2'd3, 32'd2, 0, "");
        add(1, 2'd0, 0, 32'h0, "clear_status");
        add(1, 2'd1, 0, 32'h0, "clear_pass");
        add(0, 2'd0, 32'd1, 0, "");
        add(0, 2'd1, 32'd5, 0, "");
        add(0, 2'd2, 32'd5, 0, "");
        add(0, 2'd0, 32'd2, 0, "");
        add(0, 2'd2, 32'd6, 0, "");
        add(0, 2'd0, 32'd3, 0, "");
        add(0, 2'd2, 32'd7, 0, "");
        add(1, 2'd2, 0, 32'h2, "t2_fail_cnt");
        add(1, 2'd1, 0, 32'h1, "t2_pass_cnt");
        add(1, 2'd3, 0, 32'h2, "t2_first_fail_id");
        add(1, 2'd0, 0, 32'h9, "t2_status");
        add(2, 2'd0, 0, 32'h2, "t2_ports");
        add(0, 2'd3, 32'd2, 0, "");
        add(0, 2'd0, 32'd5, 0, "");
        add(0, 2'd0, 32'd7, 0, "");
        add(1, 2'd0, 0, 32'h19, "seq_err_set");
        add(0, 2'd3, 32'd2, 0, "");
        add(0, 2'd0, 32'h7FF, 0, "");
        add(0, 2'd0, 32'h0, 0, "");
        add(1, 2'd0, 0, 32'h1, "seq_wrap_ok");
        add(0, 2'd3, 32'd2, 0, "");
        add(0, 2'd1, 32'd9, 0, "");
        add(0, 2'd2, 32'd9, 0, "");
        add(1, 2'd1, 0, 32'h0, "idle_actual_ignored");
        add(0, 2'd3, 32'd1, 0, "");
        add(1, 2'd0, 0, 32'h2, "idle_end_done");
        add(2, 2'd0, 0, 32'h1, "idle_end_ports");
        add(0, 2'd0, 32'd1, 0, "");
        add(1, 2'd0, 0, 32'h2, "done_id_ignored");
        add(0, 2'd3, 32'd3, 0, "");
        add(1, 2'd0, 0, 32'h0, "clear_beats_end");
        add(2, 2'd0, 0, 32'h0, "clear_ports");

        #1;
        check_output("in_reset_rdata", rdata, 32'h0);
        check_output("in_reset_ports", {29'd0, timeout, any_fail, done}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Read and write of the same register in one cycle returns the old value
        do_write(2'd0, 32'd1);
        do_write(2'd1, 32'd1);
        rd_en = 1'b1; wr_en = 1'b1; addr = 2'd2; wdata = 32'd2;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        check_output("rw_pre_write", rdata, 32'h0);
        do_read(2'd2);
        check_output("rw_post_write", rdata, 32'h1);
        addr = 2'd0;
        repeat (3) @(negedge clk);
        check_output("rdata_hold", rdata, 32'h1);
        do_write(2'd3, 32'd2);

        // Counter saturation on the 2-bit instance
        do_write(2'd0, 32'd1);
        do_write(2'd1, 32'hA);
        for (int k = 0; k < 5; k++) do_write(2'd2, 32'hA);
        do_read(2'd1);
        check_output("sat_wide_pass", rdata, 32'h5);
        check_output("sat_narrow_pass", rdata_sat, 32'h3);
        do_write(2'd3, 32'd2);

        // Reset in the middle of a run discards everything
        do_write(2'd0, 32'd1);
        do_write(2'd1, 32'd4);
        for (int k = 0; k < 3; k++) do_write(2'd2, 32'd4);
        do_read(2'd1);
        check_output("pre_reset_pass", rdata, 32'h3);
        rst_n = 1'b0;
        #1;
        check_output("midrun_reset_rdata", rdata, 32'h0);
        check_output("midrun_reset_ports", {29'd0, timeout, any_fail, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a));
            check_output($sformatf("post_reset_rd%0d", a), rdata, 32'h0);
        end

`ifdef RISCV_TEST_MONITOR_WATCHDOG_EN
        // Watchdog fires after sixteen RUN cycles without a new TEST_ID
        do_write(2'd0, 32'd1);
        repeat (15) @(negedge clk);
        check_output("wd_not_yet", {31'd0, timeout}, 32'h0);
        @(negedge clk);
        check_output("wd_fired", {31'd0, timeout}, 32'h1);
        do_write(2'd2, 32'hDEAD);
        do_read(2'd2);
        check_output("wd_actual_ignored", rdata, 32'h0);
        do_read(2'd0);
        check_output("wd_status", rdata, 32'hC);
`else
        // Without the watchdog a long RUN never times out
        do_write(2'd0, 32'd1);
        repeat (40) @(negedge clk);
        check_output("no_wd_timeout", {31'd0, timeout}, 32'h0);
        do_read(2'd0);
        check_output("no_wd_status", rdata, 32'h1);
`endif
        do_write(2'd3, 32'd2);
        do_read(2'd0);
        check_output("final_clear", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
